// File: rtl/cache_ctrl_pkg.sv
// Shared types for the cache miss-handling controller: FSM states, way count,
// and a one-hot to binary way helper.
package cache_ctrl_pkg;

    localparam int unsigned WAYS     = 8;
    localparam int unsigned WAY_BITS = 3;

    typedef enum logic [1:0] {
        StIdle,
        StCompare,
        StWriteback,
        StFill
    } state_t;

    // Lowest set way wins when more than one bit is set.
    function automatic logic [WAY_BITS-1:0] onehot_to_bin(input logic [WAYS-1:0] hit);
        logic [WAY_BITS-1:0] idx;
        idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit[i]) idx = WAY_BITS'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/way_encoder.sv
// One-hot hit vector to binary way index, with any-hit and multi-hit flags.
module way_encoder #(
    parameter int unsigned s_way = 3
) (
    input  logic [2**s_way-1:0] hit,
    output logic [s_way-1:0]    way,
    output logic                any_hit,
    output logic                multi_hit
);

    localparam int unsigned     Ways = 2**s_way;
    localparam logic [Ways-1:0] One  = 1;

    always_comb begin
        way = '0;
        for (int i = Ways - 1; i >= 0; i--) begin
            if (hit[i]) way = s_way'(i);
        end
    end

    assign any_hit   = |hit;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_hit = |(hit & (hit - One));

endmodule

// File: rtl/cache_control.sv
// Miss-handling FSM for the set-associative cache: hit service, dirty writeback,
// line fill and compare replay.
module cache_control
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned s_way = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [2**s_way-1:0] hit,
    input  logic [s_way-1:0]   plru_way,
    input  logic               victim_valid,
    input  logic               victim_dirty,
    input  logic               pmem_resp,
    output logic               mem_resp,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic               addr_sel,
    output logic [s_way-1:0]   way_sel,
    output logic               write_word,
    output logic               load_line,
    output logic               load_tag,
    output logic               set_valid,
    output logic               set_dirty,
    output logic               clr_dirty,
    output logic               plru_load,
    output logic [s_way-1:0]   plru_mru
);

    state_t             state_q, state_d;
    logic [s_way-1:0]   victim_q, victim_d;
    logic [s_way-1:0]   hit_way;
    logic               any_hit;
    logic               multi_hit;
    logic               req;

    assign req = mem_read | mem_write;

    way_encoder #(
        .s_way (s_way)
    ) u_way_encoder (
        .hit       (hit),
        .way       (hit_way),
        .any_hit   (any_hit),
        .multi_hit (multi_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        victim_d = victim_q;
        unique case (state_q)
            StIdle: begin
                if (req) state_d = StCompare;
            end
            StCompare: begin
                if (!req || any_hit) begin
                    state_d = StIdle;
                end else begin
                    // Victim is frozen here so a PLRU update mid-miss cannot retarget the fill.
                    victim_d = plru_way;
                    state_d  = (victim_valid && victim_dirty) ? StWriteback : StFill;
                end
            end
            StWriteback: begin
                if (pmem_resp) state_d = StFill;
            end
            StFill: begin
                if (pmem_resp) state_d = StCompare;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        addr_sel   = 1'b0;
        way_sel    = '0;
        write_word = 1'b0;
        load_line  = 1'b0;
        load_tag   = 1'b0;
        set_valid  = 1'b0;
        set_dirty  = 1'b0;
        clr_dirty  = 1'b0;
        plru_load  = 1'b0;
        plru_mru   = '0;
        unique case (state_q)
            StCompare: begin
                if (req && any_hit) begin
                    mem_resp  = 1'b1;
                    plru_load = 1'b1;
                    plru_mru  = hit_way;
                    way_sel   = hit_way;
                    if (mem_write) begin
                        write_word = 1'b1;
                        set_dirty  = 1'b1;
                    end
                end
            end
            StWriteback: begin
                pmem_write = 1'b1;
                addr_sel   = 1'b1;
                way_sel    = victim_q;
            end
            StFill: begin
                pmem_read = 1'b1;
                way_sel   = victim_q;
                if (pmem_resp) begin
                    load_line = 1'b1;
                    load_tag  = 1'b1;
                    set_valid = 1'b1;
                    clr_dirty = 1'b1;
                end
            end
            default: ;
        endcase
    end

    multi_hit_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(state_q == StCompare && req && multi_hit))
        else $error("multiple ways hit in one set");

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: directed scenarios plus randomized
// transactions checked cycle by cycle against a transaction-level model.
module tb_cache_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_read, mem_write;
    logic [7:0] hit;
    logic [2:0] plru_way;
    logic       victim_valid, victim_dirty, pmem_resp;
    logic       mem_resp, pmem_read, pmem_write, addr_sel;
    logic [2:0] way_sel, plru_mru;
    logic       write_word, load_line, load_tag, set_valid, set_dirty, clr_dirty, plru_load;

    logic [7:0] enc_hit;
    logic [2:0] enc_way;
    logic       enc_any, enc_multi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_control #(.s_way(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .hit          (hit),
        .plru_way     (plru_way),
        .victim_valid (victim_valid),
        .victim_dirty (victim_dirty),
        .pmem_resp    (pmem_resp),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .addr_sel     (addr_sel),
        .way_sel      (way_sel),
        .write_word   (write_word),
        .load_line    (load_line),
        .load_tag     (load_tag),
        .set_valid    (set_valid),
        .set_dirty    (set_dirty),
        .clr_dirty    (clr_dirty),
        .plru_load    (plru_load),
        .plru_mru     (plru_mru)
    );

    way_encoder #(.s_way(3)) u_enc (
        .hit       (enc_hit),
        .way       (enc_way),
        .any_hit   (enc_any),
        .multi_hit (enc_multi)
    );

    // {mem_resp, pmem_read, pmem_write, addr_sel, way_sel, write_word, load_line,
    //  load_tag, set_valid, set_dirty, clr_dirty, plru_load, plru_mru}
    logic [16:0] obs;
    assign obs = {mem_resp, pmem_read, pmem_write, addr_sel, way_sel, write_word, load_line,
                  load_tag, set_valid, set_dirty, clr_dirty, plru_load, plru_mru};

    typedef struct {
        logic        rd, wr, vv, vd, presp;
        logic [7:0]  hit;
        logic [2:0]  pw;
        logic [16:0] exp;
        int          phase;
    } cyc_t;

    function automatic logic [16:0] pack(input bit resp, pr, pwr, as, input int ws,
                                         input bit ww, ll, lt, sv, sd, cd, pl, input int mru);
        logic [2:0] w3, m3;
        w3 = ws[2:0];
        m3 = mru[2:0];
        return {resp, pr, pwr, as, w3, ww, ll, lt, sv, sd, cd, pl, m3};
    endfunction

    function automatic logic [7:0] way_bit(input int w);
        logic [7:0] v;
        v = 8'h01 << w;
        return v;
    endfunction

    task automatic idle_inputs();
        mem_read = 0; mem_write = 0; hit = 0; plru_way = 0;
        victim_valid = 0; victim_dirty = 0; pmem_resp = 0;
    endtask

    // One CPU request from the controller's point of view. The expected trace
    // follows directly from the request outcome: a hit answers on the second
    // cycle, a miss spends one compare cycle, optional writeback, a fill, then
    // the replayed compare hits the victim way.
    task automatic run_txn(input string name, input bit rd, input bit wr, input bit is_hit,
                           input int hway, input int victim, input bit vv, input bit vd,
                           input int wb_lat, input int fill_lat, input int mid_pw);
        cyc_t q[$];
        cyc_t c;
        bit   w_eff;
        int   rw;
        w_eff = wr;
        rw    = is_hit ? hway : victim;
        c = '{rd: rd, wr: wr, vv: 0, vd: 0, presp: 0, hit: 0, pw: 3'($urandom),
              exp: '0, phase: 0};
        q.push_back(c);
        if (!is_hit) begin
            c = '{rd: rd, wr: wr, vv: vv, vd: vd, presp: 0, hit: 0, pw: 3'(victim),
                  exp: '0, phase: 1};
            q.push_back(c);
            if (vv && vd) begin
                for (int i = 0; i < wb_lat; i++) begin
                    c = '{rd: rd, wr: wr, vv: 1, vd: 1, presp: (i == wb_lat - 1), hit: 0,
                          pw: (mid_pw < 0) ? 3'($urandom) : 3'(mid_pw),
                          exp: pack(0, 0, 1, 1, victim, 0, 0, 0, 0, 0, 0, 0, 0), phase: 2};
                    q.push_back(c);
                end
            end
            for (int i = 0; i < fill_lat; i++) begin
                bit last;
                last = (i == fill_lat - 1);
                c = '{rd: rd, wr: wr, vv: 0, vd: 0, presp: last, hit: 0,
                      pw: (mid_pw < 0) ? 3'($urandom) : 3'(mid_pw),
                      exp: pack(0, 1, 0, 0, victim, 0, last, last, last, 0, last, 0, 0),
                      phase: 3};
                q.push_back(c);
            end
        end
        c = '{rd: rd, wr: wr, vv: 0, vd: 0, presp: 0, hit: way_bit(rw), pw: 3'($urandom),
              exp: pack(1, 0, 0, 0, rw, w_eff, 0, 0, 0, w_eff, 0, 1, rw), phase: 4};
        q.push_back(c);
        foreach (q[k]) begin
            @(posedge clk);
            #1;
            mem_read = q[k].rd; mem_write = q[k].wr; hit = q[k].hit; plru_way = q[k].pw;
            victim_valid = q[k].vv; victim_dirty = q[k].vd; pmem_resp = q[k].presp;
            @(negedge clk);
            checks++;
            if (obs !== q[k].exp) begin
                errors++;
                $display("FAIL %s cycle %0d phase %0d: outputs %b, expected %b",
                         name, k, q[k].phase, obs, q[k].exp);
            end
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: outputs %b, expected all zero", obs);
        end
    endtask

    task automatic test_read_hit();
        run_txn("read_hit_way5", 1, 0, 1, 5, 0, 0, 0, 0, 0, -1);
    endtask

    task automatic test_write_hit();
        run_txn("write_hit_way2", 0, 1, 1, 2, 0, 0, 0, 0, 0, -1);
    endtask

    task automatic test_clean_miss();
        run_txn("clean_miss_way6", 1, 0, 0, 0, 6, 1, 0, 0, 3, -1);
    endtask

    task automatic test_dirty_miss();
        run_txn("dirty_miss_way3", 0, 1, 0, 0, 3, 1, 1, 2, 3, 0);
    endtask

    task automatic test_both_rw();
        run_txn("rd_wr_hit_way0", 1, 1, 1, 0, 0, 0, 0, 0, 0, -1);
    endtask

    task automatic test_dropped_request();
        @(posedge clk); #1 idle_inputs(); mem_read = 1;
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL dropped_compare: outputs %b, expected all zero", obs);
        end
        @(posedge clk); #1 idle_inputs(); pmem_resp = 1;
        @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL stray_pmem_resp_idle: outputs %b, expected all zero", obs);
        end
        run_txn("after_drop_read_hit", 1, 0, 1, 4, 0, 0, 0, 0, 0, -1);
    endtask

    task automatic test_reset_in_fill();
        @(posedge clk); #1 idle_inputs(); mem_read = 1;
        @(posedge clk); #1 plru_way = 3'd1; victim_valid = 1; victim_dirty = 0;
        @(posedge clk); #1 plru_way = 3'd7;
        @(negedge clk);
        checks++;
        if ({pmem_read, way_sel} !== {1'b1, 3'd1}) begin
            errors++;
            $display("FAIL fill_before_reset: pmem_read/way_sel %b/%0d, expected 1/1",
                     pmem_read, way_sel);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL async_reset_in_fill: outputs %b, expected all zero", obs);
        end
        idle_inputs();
        @(posedge clk);
        #3 rst_n = 1;
        run_txn("after_reset_read_hit", 1, 0, 1, 1, 0, 0, 0, 0, 0, -1);
    endtask

    task automatic test_encoder();
        logic [7:0] pats[3];
        logic [4:0] exps[3];
        pats[0] = 8'h03; exps[0] = {3'd0, 1'b1, 1'b1};
        pats[1] = 8'h80; exps[1] = {3'd7, 1'b1, 1'b0};
        pats[2] = 8'h00; exps[2] = {3'd0, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            enc_hit = pats[i];
            #1;
            checks++;
            if ({enc_way, enc_any, enc_multi} !== exps[i]) begin
                errors++;
                $display("FAIL encoder_%h: way/any/multi %0d/%b/%b, expected %0d/%b/%b",
                         pats[i], enc_way, enc_any, enc_multi,
                         exps[i][4:2], exps[i][1], exps[i][0]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            bit rd, wr, hh, vv, vd;
            int gap;
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1;
            hh = 1'($urandom);
            vv = 1'($urandom);
            vd = 1'($urandom);
            run_txn("random_txn", rd, wr, hh, $urandom_range(0, 7), $urandom_range(0, 7), vv, vd,
                    $urandom_range(1, 4), $urandom_range(1, 4), -1);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1 idle_inputs();
                pmem_resp = 1'($urandom); plru_way = 3'($urandom);
                @(negedge clk);
                checks++;
                if (obs !== '0) begin
                    errors++;
                    $display("FAIL random_idle_gap: outputs %b, expected all zero", obs);
                end
            end
        end
    endtask

    initial begin
        enc_hit = 0;
        test_reset();
        test_encoder();
        test_read_hit();
        test_write_hit();
        test_clean_miss();
        test_dirty_miss();
        test_both_rw();
        test_dropped_request();
        test_reset_in_fill();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
